// File: rtl/clk_reset_sequencer.sv
// Power-up sequencer: filters the PLL lock, holds the downstream reset for a
// fixed time, then runs a divided clock-enable and counts lock losses.
module clk_reset_sequencer #(
  parameter int LOCK_FILTER = 8,
  parameter int HOLD_CYCLES = 16,
  parameter int CE_DIV      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       locked_in,
  input  logic       drop_clr,
  output logic       sys_reset,
  output logic       ready,
  output logic       ce,
  output logic [1:0] state,
  output logic [7:0] drop_count
);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    FILTER    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam logic [7:0] FILT_LAST = 8'(LOCK_FILTER - 1);
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [4:0] DIV_LAST  = 5'(CE_DIV - 1);

  state_t     cur, nxt;
  logic       sync1, locked_s;
  logic [7:0] phase, phase_nxt;
  logic [4:0] div, div_nxt;
  logic [7:0] drop_nxt;
  logic       drop_ev;

  always_comb begin
    nxt       = cur;
    phase_nxt = phase;
    div_nxt   = '0;
    drop_ev   = 1'b0;
    case (cur)
      WAIT_LOCK: begin
        if (locked_s) begin
          nxt       = FILTER;
          phase_nxt = '0;
        end
      end
      FILTER: begin
        if (!locked_s) begin
          nxt       = WAIT_LOCK;
          phase_nxt = '0;
        end else if (phase == FILT_LAST) begin
          nxt       = HOLD;
          phase_nxt = '0;
        end else begin
          phase_nxt = phase + 8'd1;
        end
      end
      HOLD: begin
        if (!locked_s) begin
          nxt       = WAIT_LOCK;
          phase_nxt = '0;
          drop_ev   = 1'b1;
        end else if (phase == HOLD_LAST) begin
          nxt       = RUN;
          phase_nxt = '0;
        end else begin
          phase_nxt = phase + 8'd1;
        end
      end
      RUN: begin
        if (!locked_s) begin
          nxt     = WAIT_LOCK;
          drop_ev = 1'b1;
        end else begin
          div_nxt = (div == DIV_LAST) ? 5'd0 : div + 5'd1;
        end
      end
      default: nxt = WAIT_LOCK;
    endcase
  end

  // A clear that lands on a drop still records that drop.
  always_comb begin
    drop_nxt = drop_count;
    if (drop_clr)
      drop_nxt = drop_ev ? 8'd1 : 8'd0;
    else if (drop_ev && drop_count != 8'hff)
      drop_nxt = drop_count + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1      <= 1'b0;
      locked_s   <= 1'b0;
      cur        <= WAIT_LOCK;
      phase      <= '0;
      div        <= '0;
      drop_count <= '0;
      sys_reset  <= 1'b1;
      ready      <= 1'b0;
    end else begin
      sync1      <= locked_in;
      locked_s   <= sync1;
      cur        <= nxt;
      phase      <= phase_nxt;
      div        <= div_nxt;
      drop_count <= drop_nxt;
      sys_reset  <= (nxt != RUN);
      ready      <= (nxt == RUN);
    end
  end

  // ready mirrors state==RUN, so ce can never coincide with sys_reset.
  assign ce    = ready && (div == DIV_LAST);
  assign state = cur;

endmodule

// File: doc/clk_reset_sequencer.md
CLK_RESET_SEQUENCER -- requirements
Module: clk_reset_sequencer

Interface
REQ-001 SHALL provide parameter LOCK_FILTER, default 8: cycles the synchronized lock must stay high before the reset hold starts (legal 1..255).
REQ-002 SHALL provide parameter HOLD_CYCLES, default 16: cycles sys_reset stays asserted after the lock is filtered (legal 1..255).
REQ-003 SHALL provide parameter CE_DIV, default 4: clock-enable divide ratio in RUN (legal 1..16).
REQ-004 SHALL have port clk, input, 1: single system clock, fed by the PLL output via global buffer; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port locked_in, input, 1: PLL LOCKED, asynchronous to clk.
REQ-007 SHALL have port drop_clr, input, 1: synchronous clear of drop_count.
REQ-008 SHALL have port sys_reset, output, 1: registered, active-high reset to the downstream game logic.
REQ-009 SHALL have port ready, output, 1: registered, high only in RUN.
REQ-010 SHALL have port ce, output, 1: one-cycle clock-enable pulse, active only in RUN.
REQ-011 SHALL have port state, output, 2: current state (WAIT_LOCK=0, FILTER=1, HOLD=2, RUN=3).
REQ-012 SHALL have port drop_count, output, 8: saturating count of lock losses in HOLD or RUN.

Function
REQ-013 SHALL pass locked_in through a 2-flop synchronizer, producing locked_s; a rise sampled at edge k appears on locked_s after edge k+1.
REQ-014 WAIT_LOCK SHALL transition to FILTER on the edge where locked_s=1 and SHALL clear the phase counter.
REQ-015 FILTER SHALL last exactly LOCK_FILTER cycles with locked_s=1, then transition to HOLD with the phase counter cleared; locked_s=0 at any FILTER edge SHALL return to WAIT_LOCK without touching drop_count.
REQ-016 HOLD SHALL last exactly HOLD_CYCLES cycles, then transition to RUN; locked_s=0 in HOLD SHALL return to WAIT_LOCK and increment drop_count.
REQ-017 RUN SHALL persist while locked_s=1; locked_s=0 SHALL return to WAIT_LOCK and increment drop_count.
REQ-018 sys_reset SHALL be 1 in every state but RUN; it SHALL update on the same edge as state. Deassertion occurs on the edge entering RUN; reassertion occurs on the edge leaving RUN.
REQ-019 ready SHALL equal (state==RUN), registered with state.
REQ-020 The divider counter SHALL be 0 on entering RUN and SHALL increment modulo CE_DIV each RUN cycle; it SHALL be held at 0 outside RUN.
REQ-021 ce SHALL be 1 exactly in RUN cycles where the divider equals CE_DIV-1, giving its first pulse in the CE_DIV-th RUN cycle. For CE_DIV=1, ce SHALL be constantly 1 in RUN.
REQ-022 ce SHALL never be 1 while sys_reset=1.
REQ-023 drop_count SHALL saturate at 255.
REQ-024 drop_clr alone SHALL zero drop_count; drop_clr coincident with a drop SHALL yield 1.
REQ-025 Phase counter width SHALL be 8 bits, and comparisons SHALL be against parameter-1, with no wrap-around in legal ranges.

Reset
REQ-026 reset=1 SHALL, on the next edge, force state=WAIT_LOCK, synchronizer flops=0, counters=0, drop_count=0, sys_reset=1, ready=0, ce=0.
REQ-027 reset SHALL take priority over every transition, drop_clr and drop counting; reset asserted mid-RUN SHALL behave as REQ-026 and SHALL NOT increment drop_count.
REQ-028 After reset releases with locked_in already high, the sequence SHALL restart from WAIT_LOCK per REQ-013..REQ-018.

Verification
REQ-029 Bench SHALL cover: defaults, locked_in rises sampled at edge k -> FILTER at k+2, HOLD at k+10, RUN with sys_reset=0 and ready=1 at k+26.
REQ-030 Bench SHALL cover: locked_in glitch high for 5 cycles during FILTER -> return to WAIT_LOCK, sys_reset stays 1, drop_count=0.
REQ-031 Bench SHALL cover: CE_DIV=4, in RUN for 12 cycles -> ce pulses in RUN cycles 4, 8 and 12 only, each 1 cycle wide.
REQ-032 Bench SHALL cover: locked_in low during RUN -> sys_reset=1, ready=0 and ce=0 two edges after the sampled drop, drop_count=1, then a full relock sequence of 26 cycles.
REQ-033 Bench SHALL cover: 300 lock drops, then drop_clr coincident with a drop -> drop_count holds at 255, then reads 1.
REQ-034 Bench SHALL cover: reset pulsed mid-HOLD with locked_in high -> WAIT_LOCK next edge, drop_count=0, RUN reached 26 cycles after reset release.
